// File: rtl/ahb_slave_responder_if.sv
// AHB-Lite slave-side signal bundle for ahb_slave_responder.
// An address phase is taken on a rising edge where hselx & hready & htrans[1];
// the slave stalls its data phase by holding hreadyout low, and the bus only
// advances when hready (normally this slave's hreadyout) is high.
interface ahb_slave_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  hselx;
   logic [ADDR_WIDTH-1:0] haddr;
   logic [1:0]            htrans;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [2:0]            hburst;
   logic [3:0]            hprot;
   logic                  hmastlock;
   logic [DATA_WIDTH-1:0] hwdata;
   logic                  hready;
   logic                  hreadyout;
   logic [DATA_WIDTH-1:0] hrdata;
   logic [1:0]            hresp;

   modport slave (
      input  hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
      input  hwdata, hready,
      output hreadyout, hrdata, hresp
   );

   modport master (
      output hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
      output hwdata, hready,
      input  hreadyout, hrdata, hresp
   );
endinterface

// File: rtl/ahb_slave_responder.sv
// AHB-Lite memory slave: byte-addressed backing store with optional wait states
// and a two-cycle ERROR response for misaligned, oversized or out-of-range transfers.
module ahb_slave_responder #(
   parameter int                    ADDR_WIDTH        = 32,
   parameter int                    DATA_WIDTH        = 32,
   parameter int                    SLAVE_MEMORY_SIZE = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR         = '0,
   parameter int                    WAIT_STATES       = 0
) (
   input  logic                      hclk,
   input  logic                      hresetn,
   ahb_slave_responder_if.slave      bus,
   output logic [2:0]                dbg_state,
   output logic [3:0]                dbg_wait_cnt,
   output logic [2:0]                dbg_hburst,
   output logic [3:0]                dbg_hprot,
   output logic                      dbg_hmastlock
);

   localparam int              NUM_LANES = DATA_WIDTH / 8;
   localparam int              MEM_BYTES = 1 << SLAVE_MEMORY_SIZE;
   localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_STATES - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_t;

   state_t                       state_q, state_d;
   logic [3:0]                   wait_cnt_q, wait_cnt_d;
   logic                         capture;

   logic [SLAVE_MEMORY_SIZE-1:0] addr_q;
   logic                         write_q;
   logic [2:0]                   size_q;
   logic [2:0]                   burst_q;
   logic [3:0]                   prot_q;
   logic                         mastlock_q;

   logic [7:0]                   mem [MEM_BYTES];

   logic                         accept;
   logic                         illegal;
   logic                         misaligned;
   logic [ADDR_WIDTH:0]          diff;
   logic [3:0]                   lane_en;
   logic [DATA_WIDTH-1:0]        rd_word;

   // Address-phase decode; the extra diff bit is the borrow of haddr - BASE_ADDR.
   assign accept = bus.hselx & bus.hready & bus.htrans[1];
   assign diff   = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};

   always_comb begin
      misaligned = 1'b0;
      case (bus.hsize)
         3'd1:    misaligned = bus.haddr[0];
         3'd2:    misaligned = |bus.haddr[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign illegal = (bus.hsize > 3'd2) | misaligned | diff[ADDR_WIDTH] |
                    (|diff[ADDR_WIDTH-1:SLAVE_MEMORY_SIZE]);

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // WAIT and ERR1 hold hreadyout low, so no address phase can complete there.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      capture    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            if (accept) begin
               capture = 1'b1;
               if (illegal) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = WAIT_LOAD;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == 4'd0) begin
               state_d = ST_DATA;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         addr_q     <= '0;
         write_q    <= 1'b0;
         size_q     <= 3'd0;
         burst_q    <= 3'd0;
         prot_q     <= 4'd0;
         mastlock_q <= 1'b0;
      end else if (capture) begin
         addr_q     <= diff[SLAVE_MEMORY_SIZE-1:0];
         write_q    <= bus.hwrite;
         size_q     <= bus.hsize;
         burst_q    <= bus.hburst;
         prot_q     <= bus.hprot;
         mastlock_q <= bus.hmastlock;
      end
   end

   // Byte lanes follow the little-endian offset within the 32-bit word.
   always_comb begin
      lane_en = 4'b0000;
      case (size_q)
         3'd0:    lane_en = 4'b0001 << addr_q[1:0];
         3'd1:    lane_en = 4'b0011 << {addr_q[1], 1'b0};
         default: lane_en = 4'b1111;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i] <= 8'h00;
         end
      end else if (state_q == ST_DATA && write_q) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_en[i]) begin
               mem[{addr_q[SLAVE_MEMORY_SIZE-1:2], 2'(i)}] <= bus.hwdata[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_en[i]) begin
            rd_word[8*i +: 8] = mem[{addr_q[SLAVE_MEMORY_SIZE-1:2], 2'(i)}];
         end
      end
   end

   assign bus.hrdata    = (state_q == ST_DATA && !write_q) ? rd_word : '0;
   assign bus.hreadyout = !(state_q == ST_WAIT || state_q == ST_ERR1);
   assign bus.hresp     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? 2'b01 : 2'b00;

   assign dbg_state     = state_q;
   assign dbg_wait_cnt  = wait_cnt_q;
   assign dbg_hburst    = burst_q;
   assign dbg_hprot     = prot_q;
   assign dbg_hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Directed bench for ahb_slave_responder: one instance with no wait states and
// one with three, sharing stimulus; tgt picks which one is selected.
module tb_ahb_slave_responder;

   logic hclk;
   logic rst0_n, rst3_n;

   logic        tgt;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;

   int n_cmp;
   int n_err;

   ahb_slave_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   ahb_slave_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

   logic [2:0] dbg_state0, dbg_state3, dbg_burst0, dbg_burst3;
   logic [3:0] dbg_cnt0, dbg_cnt3, dbg_prot0, dbg_prot3;
   logic       dbg_lock0, dbg_lock3;

   ahb_slave_responder #(.WAIT_STATES(0)) dut0 (
      .hclk(hclk), .hresetn(rst0_n), .bus(bus0.slave),
      .dbg_state(dbg_state0), .dbg_wait_cnt(dbg_cnt0), .dbg_hburst(dbg_burst0),
      .dbg_hprot(dbg_prot0), .dbg_hmastlock(dbg_lock0)
   );

   ahb_slave_responder #(.WAIT_STATES(3)) dut3 (
      .hclk(hclk), .hresetn(rst3_n), .bus(bus3.slave),
      .dbg_state(dbg_state3), .dbg_wait_cnt(dbg_cnt3), .dbg_hburst(dbg_burst3),
      .dbg_hprot(dbg_prot3), .dbg_hmastlock(dbg_lock3)
   );

   assign bus0.hselx     = hsel & ~tgt;
   assign bus3.hselx     = hsel & tgt;
   assign bus0.haddr     = haddr;
   assign bus3.haddr     = haddr;
   assign bus0.htrans    = htrans;
   assign bus3.htrans    = htrans;
   assign bus0.hwrite    = hwrite;
   assign bus3.hwrite    = hwrite;
   assign bus0.hsize     = hsize;
   assign bus3.hsize     = hsize;
   assign bus0.hburst    = 3'd0;
   assign bus3.hburst    = 3'd0;
   assign bus0.hprot     = 4'b0011;
   assign bus3.hprot     = 4'b0011;
   assign bus0.hmastlock = 1'b0;
   assign bus3.hmastlock = 1'b0;
   assign bus0.hwdata    = hwdata;
   assign bus3.hwdata    = hwdata;
   assign bus0.hready    = bus0.hreadyout;
   assign bus3.hready    = bus3.hreadyout;

   logic        cur_ready;
   logic [1:0]  cur_resp;
   logic [31:0] cur_rdata;
   assign cur_ready = tgt ? bus3.hreadyout : bus0.hreadyout;
   assign cur_resp  = tgt ? bus3.hresp     : bus0.hresp;
   assign cur_rdata = tgt ? bus3.hrdata    : bus0.hrdata;

   // Clock / reset
   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver: one non-pipelined transfer, entered and left 1 time unit after a rising edge.
   task automatic xfer(input bit t, input bit wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wd,
                       output logic [31:0] rd, output logic [1:0] resp,
                       output int waits, output logic r0, output logic [1:0] p0);
      bit first;
      tgt = t; hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = 3'd0; hwdata = wd;
      waits = 0; first = 1'b1; r0 = 1'b0; p0 = 2'b00;
      forever begin
         @(negedge hclk);
         if (first) begin
            r0 = cur_ready; p0 = cur_resp; first = 1'b0;
         end
         if (cur_ready) break;
         waits++;
         if (waits > 20) begin
            n_cmp++; n_err++;
            $display("FAIL xfer_timeout: hreadyout stuck low at addr %h", addr);
            break;
         end
      end
      rd = cur_rdata; resp = cur_resp;
      @(posedge hclk); #1;
      hwdata = '0;
   endtask

   logic [31:0] rd;
   logic [1:0]  resp, p0;
   logic        r0;
   int          waits;

   task automatic test_reset();
      n_cmp++;
      if (bus0.hreadyout !== 1'b1 || bus3.hreadyout !== 1'b1) begin
         n_err++; $display("FAIL reset_ready: got %b/%b exp 1/1", bus0.hreadyout, bus3.hreadyout);
      end
      n_cmp++;
      if (bus0.hresp !== 2'b00 || bus3.hresp !== 2'b00) begin
         n_err++; $display("FAIL reset_resp: got %b/%b exp 00/00", bus0.hresp, bus3.hresp);
      end
      n_cmp++;
      if (bus0.hrdata !== 32'h0 || bus3.hrdata !== 32'h0) begin
         n_err++; $display("FAIL reset_rdata: got %h/%h exp 0", bus0.hrdata, bus3.hrdata);
      end
      xfer(1'b0, 1'b0, 32'h0000_0040, 3'd2, 32'h0, rd, resp, waits, r0, p0);
      n_cmp++;
      if (rd !== 32'h0) begin
         n_err++; $display("FAIL reset_mem: got %h exp 00000000", rd);
      end
   endtask

   task automatic test_word_rw();
      xfer(1'b0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, resp, waits, r0, p0);
      n_cmp++;
      if (waits !== 0 || resp !== 2'b00) begin
         n_err++; $display("FAIL word_write: waits %0d resp %b exp 0 00", waits, resp);
      end
      xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, rd, resp, waits, r0, p0);
      n_cmp++;
      if (waits !== 0 || resp !== 2'b00) begin
         n_err++; $display("FAIL word_read_status: waits %0d resp %b exp 0 00", waits, resp);
      end
      n_cmp++;
      if (rd !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL word_read_data: got %h exp deadbeef", rd);
      end
      @(negedge hclk);
      n_cmp++;
      if (bus0.hrdata !== 32'h0) begin
         n_err++; $display("FAIL rdata_idle_zero: got %h exp 00000000", bus0.hrdata);
      end
      @(posedge hclk); #1;
   endtask

   task automatic test_byte_lanes();
      xfer(1'b0, 1'b1, 32'h10, 3'd2, 32'h11223344, rd, resp, waits, r0, p0);
      xfer(1'b0, 1'b1, 32'h13, 3'd0, 32'hAAAAAAAA, rd, resp, waits, r0, p0);
      xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, rd, resp, waits, r0, p0);
      n_cmp++;
      if (rd !== 32'hAA223344) begin
         n_err++; $display("FAIL byte_write_merge: got %h exp aa223344", rd);
      end
      xfer(1'b0, 1'b0, 32'h12, 3'd0, 32'h0, rd, resp, waits, r0, p0);
      n_cmp++;
      if (rd !== 32'h00220000) begin
         n_err++; $display("FAIL byte_read_lane: got %h exp 00220000", rd);
      end
      xfer(1'b0, 1'b0, 32'h10, 3'd1, 32'h0, rd, resp, waits, r0, p0);
      n_cmp++;
      if (rd !== 32'h00003344) begin
         n_err++; $display("FAIL half_read_lane: got %h exp 00003344", rd);
      end
   endtask

   task automatic test_wait_states();
      xfer(1'b1, 1'b1, 32'h08, 3'd2, 32'h12345678, rd, resp, waits, r0, p0);
      n_cmp++;
      if (waits !== 3 || resp !== 2'b00) begin
         n_err++; $display("FAIL ws_write: waits %0d resp %b exp 3 00", waits, resp);
      end
      xfer(1'b1, 1'b0, 32'h08, 3'd2, 32'h0, rd, resp, waits, r0, p0);
      n_cmp++;
      if (waits !== 3 || r0 !== 1'b0 || p0 !== 2'b00) begin
         n_err++; $display("FAIL ws_read_wait: waits %0d first %b/%b exp 3 0/00", waits, r0, p0);
      end
      n_cmp++;
      if (rd !== 32'h12345678 || resp !== 2'b00) begin
         n_err++; $display("FAIL ws_read_data: got %h %b exp 12345678 00", rd, resp);
      end
   endtask

   task automatic test_errors();
      xfer(1'b0, 1'b1, 32'h00, 3'd2, 32'hCAFEF00D, rd, resp, waits, r0, p0);
      xfer(1'b0, 1'b1, 32'h01, 3'd1, 32'hFFFFFFFF, rd, resp, waits, r0, p0);
      n_cmp++;
      if (r0 !== 1'b0 || p0 !== 2'b01 || waits !== 1 || resp !== 2'b01) begin
         n_err++; $display("FAIL err_misaligned: ERR1 %b/%b ERR2 resp %b waits %0d exp 0/01 01 1", r0, p0, resp, waits);
      end
      xfer(1'b0, 1'b1, 32'h400, 3'd2, 32'h0BADBAD0, rd, resp, waits, r0, p0);
      n_cmp++;
      if (r0 !== 1'b0 || p0 !== 2'b01 || waits !== 1 || resp !== 2'b01) begin
         n_err++; $display("FAIL err_range: ERR1 %b/%b ERR2 resp %b waits %0d exp 0/01 01 1", r0, p0, resp, waits);
      end
      xfer(1'b0, 1'b0, 32'h08, 3'd3, 32'h0, rd, resp, waits, r0, p0);
      n_cmp++;
      if (r0 !== 1'b0 || p0 !== 2'b01 || resp !== 2'b01 || rd !== 32'h0) begin
         n_err++; $display("FAIL err_size: ERR1 %b/%b ERR2 resp %b rdata %h exp 0/01 01 0", r0, p0, resp, rd);
      end
      xfer(1'b0, 1'b0, 32'h00, 3'd2, 32'h0, rd, resp, waits, r0, p0);
      n_cmp++;
      if (rd !== 32'hCAFEF00D || resp !== 2'b00) begin
         n_err++; $display("FAIL err_no_write: got %h %b exp cafef00d 00", rd, resp);
      end
   endtask

   task automatic test_back_to_back();
      tgt = 1'b0; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
      @(posedge hclk); #1;
      hwrite = 1'b0; hwdata = 32'h00000055;
      @(negedge hclk);
      n_cmp++;
      if (bus0.hreadyout !== 1'b1 || bus0.hresp !== 2'b00) begin
         n_err++; $display("FAIL b2b_write_stall: ready %b resp %b exp 1 00", bus0.hreadyout, bus0.hresp);
      end
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00; haddr = '0; hwdata = '0;
      @(negedge hclk);
      n_cmp++;
      if (bus0.hreadyout !== 1'b1 || bus0.hrdata !== 32'h00000055 || bus0.hresp !== 2'b00) begin
         n_err++; $display("FAIL b2b_read: ready %b rdata %h resp %b exp 1 00000055 00", bus0.hreadyout, bus0.hrdata, bus0.hresp);
      end
      @(posedge hclk); #1;
   endtask

   task automatic test_reset_mid_wait();
      tgt = 1'b1; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = 32'h77777777;
      @(negedge hclk);
      n_cmp++;
      if (bus3.hreadyout !== 1'b0) begin
         n_err++; $display("FAIL rst_pre_wait: ready %b exp 0", bus3.hreadyout);
      end
      #2 rst3_n = 1'b0;
      #1;
      n_cmp++;
      if (bus3.hreadyout !== 1'b1 || bus3.hresp !== 2'b00 || bus3.hrdata !== 32'h0) begin
         n_err++; $display("FAIL rst_async: ready %b resp %b rdata %h exp 1 00 0", bus3.hreadyout, bus3.hresp, bus3.hrdata);
      end
      @(posedge hclk); #2 rst3_n = 1'b1; hwdata = '0;
      @(posedge hclk); #1;
      xfer(1'b1, 1'b0, 32'h30, 3'd2, 32'h0, rd, resp, waits, r0, p0);
      n_cmp++;
      if (rd !== 32'h0 || resp !== 2'b00 || waits !== 3) begin
         n_err++; $display("FAIL rst_no_write: got %h %b waits %0d exp 0 00 3", rd, resp, waits);
      end
      xfer(1'b1, 1'b0, 32'h08, 3'd2, 32'h0, rd, resp, waits, r0, p0);
      n_cmp++;
      if (rd !== 32'h0) begin
         n_err++; $display("FAIL rst_clears_mem: got %h exp 00000000", rd);
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      tgt = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
      hsize = 3'd0; hwdata = '0;
      rst0_n = 1'b0; rst3_n = 1'b0;
      #23;
      test_reset();
      rst0_n = 1'b1; rst3_n = 1'b1;
      @(posedge hclk); #1;
      test_reset();
      test_word_rw();
      test_byte_lanes();
      test_wait_states();
      test_errors();
      test_back_to_back();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_slave_responder.md
AHB_SLAVE_RESPONDER -- requirements
Module: ahb_slave_responder

Interface
REQ-001 Parameter ADDR_WIDTH, 32, address bus width.
REQ-002 Parameter DATA_WIDTH, 32, data bus width; only 32 is supported.
REQ-003 Parameter SLAVE_MEMORY_SIZE, 10, log2 of the backing store size in bytes.
REQ-004 Parameter BASE_ADDR, 0, first byte address decoded to this slave.
REQ-005 Parameter WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..15).
REQ-006 Ports:
- hclk  in  1  clock, all logic on the rising edge
- hresetn  in  1  reset; asynchronous assert, active-low
- hselx  in  1  slave select
- haddr  in  ADDR_WIDTH  address
- htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwrite  in  1  1 = write
- hsize  in  3  transfer size
- hburst  in  3  burst type; captured, no functional effect
- hprot  in  4  protection; captured, no functional effect
- hmastlock  in  1  lock; captured, no functional effect
- hwdata  in  32  write data
- hready  in  1  bus-wide ready
- hreadyout  out  1  slave ready
- hrdata  out  32  read data
- hresp  out  2  00 OKAY, 01 ERROR

Function
REQ-007 Address phase SHALL be accepted only on a clock edge where hselx=1, hready=1 and htrans is NONSEQ or SEQ.
REQ-008 At acceptance, haddr, hwrite, hsize, hburst, hprot and hmastlock SHALL be registered for the data phase.
REQ-009 IDLE, BUSY or hselx=0 with hready=1 SHALL move the FSM to IDLE; no memory access; next cycle hreadyout=1, hresp=OKAY.
REQ-010 FSM states SHALL be IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-011 From IDLE or DATA:
- accepted legal transfer -> WAIT if WAIT_STATES>0, else DATA
- accepted illegal transfer -> ERR1
REQ-012 WAIT SHALL hold hreadyout=0 and hresp=OKAY for exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then enter DATA.
REQ-013 DATA SHALL drive hreadyout=1 and hresp=OKAY for one cycle, then leave per REQ-009/REQ-011.
REQ-014 An accepted transfer is illegal if any of the following holds:
- hsize>2
- haddr not aligned to 2^hsize
- haddr<BASE_ADDR
- haddr-BASE_ADDR >= 2^SLAVE_MEMORY_SIZE
REQ-015 ERR1 SHALL drive hreadyout=0, hresp=01 for one cycle; ERR2 SHALL drive hreadyout=1, hresp=01 for one cycle; an illegal transfer SHALL NOT access memory.
REQ-016 A transfer presented in the ERR2 cycle is accepted normally, per REQ-007.
REQ-017 Backing store SHALL be 2^SLAVE_MEMORY_SIZE bytes, little-endian, indexed by haddr-BASE_ADDR.
REQ-018 Writes SHALL commit on the DATA-cycle edge using hwdata from that cycle.
REQ-019 Write byte lanes SHALL be selected by hsize and offset[1:0]: byte -> 1 lane, halfword -> 2 lanes, word -> 4 lanes.
REQ-020 Reads SHALL drive hrdata during the DATA cycle: addressed bytes on their natural lanes, unaddressed lanes 0.
REQ-021 hrdata SHALL be 0 in every cycle other than a read DATA cycle.
REQ-022 A read whose address phase overlaps the DATA cycle of a write to the same bytes SHALL return the new write data.
REQ-023 hreadyout SHALL be 0 only in WAIT and ERR1.
REQ-024 Pipelined back-to-back transfers SHALL sustain one transfer per cycle when WAIT_STATES=0.

Reset
REQ-025 While hresetn=0:
- FSM=IDLE, wait counter=0
- hreadyout=1, hresp=00, hrdata=0
- all backing-store bytes=0
REQ-026 Reset asserted mid-WAIT/DATA/ERR SHALL drop the pending transfer with no memory write; the first address phase after deassertion is accepted normally.

Verification
REQ-027 WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 -> OKAY, zero waits, hrdata=0xDEADBEEF.
REQ-028 Byte write 0xAA @0x13 over word 0x11223344 @0x10, then word read @0x10 -> 0xAA223344.
REQ-029 WAIT_STATES=3: read -> hreadyout low exactly 3 cycles, then data with OKAY.
REQ-030 Halfword @0x01, and word @0x400 with SLAVE_MEMORY_SIZE=10 -> ERR1 (ready 0, resp 01), ERR2 (ready 1, resp 01); memory unchanged.
REQ-031 Pipelined write 0x55 @0x20 followed by read @0x20 in consecutive cycles -> read returns 0x55, no stall.
REQ-032 hresetn low during a WAIT state -> hreadyout=1 immediately; no memory write; next transfer completes OKAY.
